// File: rtl/voter_session.sv
// Weighted-ballot session tallier: three voter classes, once-per-session voting,
// saturating running tally, registered final result and threshold verdict.
module voter_session #(
    parameter int NP_W    = 32,
    parameter int VIP_W   = 8,
    parameter int VVIP_W  = 1,
    parameter int NP_WT   = 1,
    parameter int VIP_WT  = 4,
    parameter int VVIP_WT = 16,
    parameter int RES_W   = 8,
    parameter int THRESH  = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              close,
    input  logic [NP_W-1:0]   np,
    input  logic [VIP_W-1:0]  vip,
    input  logic [VVIP_W-1:0] vvip,
    output logic [RES_W-1:0]  result,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        state_dbg
);

    // Handshake: start is sampled only in IDLE and close only in OPEN; each is
    // a level sampled on the rising edge, there is no ready/ack back-channel.

    localparam int MAX_INC = NP_W * NP_WT + VIP_W * VIP_WT + VVIP_W * VVIP_WT;
    localparam int MAX_RES = (2 ** RES_W) - 1;
    localparam int SUM_W   = $clog2(MAX_RES + MAX_INC + 1);
    localparam logic [SUM_W-1:0] SAT_VAL = SUM_W'(MAX_RES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               pass_q, pass_d;
    logic [NP_W-1:0]    mask_np_q, mask_np_d;
    logic [VIP_W-1:0]   mask_vip_q, mask_vip_d;
    logic [VVIP_W-1:0]  mask_vvip_q, mask_vvip_d;

    logic [NP_W-1:0]    new_np;
    logic [VIP_W-1:0]   new_vip;
    logic [VVIP_W-1:0]  new_vvip;
    logic [SUM_W-1:0]   inc;
    logic [SUM_W-1:0]   sum;
    logic [RES_W-1:0]   sat_result;

    assign new_np   = np & ~mask_np_q;
    assign new_vip  = vip & ~mask_vip_q;
    assign new_vvip = vvip & ~mask_vvip_q;

    always_comb begin
        inc = '0;
        for (int i = 0; i < NP_W; i++)
            if (new_np[i]) inc = inc + SUM_W'(NP_WT);
        for (int i = 0; i < VIP_W; i++)
            if (new_vip[i]) inc = inc + SUM_W'(VIP_WT);
        for (int i = 0; i < VVIP_W; i++)
            if (new_vvip[i]) inc = inc + SUM_W'(VVIP_WT);
    end

    // SUM_W is sized so the full-scale tally plus the largest increment cannot wrap.
    assign sum        = SUM_W'(result_q) + inc;
    assign sat_result = (sum > SAT_VAL) ? RES_W'(MAX_RES) : sum[RES_W-1:0];

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        pass_d      = pass_q;
        mask_np_d   = mask_np_q;
        mask_vip_d  = mask_vip_q;
        mask_vvip_d = mask_vvip_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = OPEN;
                    result_d    = '0;
                    pass_d      = 1'b0;
                    mask_np_d   = '0;
                    mask_vip_d  = '0;
                    mask_vvip_d = '0;
                end
            end
            OPEN: begin
                mask_np_d   = mask_np_q | np;
                mask_vip_d  = mask_vip_q | vip;
                mask_vvip_d = mask_vvip_q | vvip;
                result_d    = sat_result;
                if (close) begin
                    state_d = DONE;
                    pass_d  = (32'(sat_result) >= THRESH);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            result_q    <= '0;
            pass_q      <= 1'b0;
            mask_np_q   <= '0;
            mask_vip_q  <= '0;
            mask_vvip_q <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            pass_q      <= pass_d;
            mask_np_q   <= mask_np_d;
            mask_vip_q  <= mask_vip_d;
            mask_vvip_q <= mask_vvip_d;
        end
    end

    assign result    = result_q;
    assign pass      = pass_q;
    assign busy      = (state_q == OPEN);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_voter_session.sv
// Directed bench for voter_session: default-parameter instance plus a RES_W=6
// instance for saturation.
module tb_voter_session;

    logic        clk;
    logic        reset;
    logic        start, close;
    logic [31:0] np;
    logic [7:0]  vip;
    logic [0:0]  vvip;
    logic [7:0]  result;
    logic        busy, done, pass;
    logic [1:0]  state_dbg;

    logic        s_start, s_close;
    logic [31:0] s_np;
    logic [7:0]  s_vip;
    logic [0:0]  s_vvip;
    logic [5:0]  s_result;
    logic        s_busy, s_done, s_pass;
    logic [1:0]  s_state_dbg;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OPEN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    voter_session u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .close     (close),
        .np        (np),
        .vip       (vip),
        .vvip      (vvip),
        .result    (result),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .state_dbg (state_dbg)
    );

    voter_session #(.RES_W(6)) u_sat (
        .clk       (clk),
        .reset     (reset),
        .start     (s_start),
        .close     (s_close),
        .np        (s_np),
        .vip       (s_vip),
        .vvip      (s_vvip),
        .result    (s_result),
        .busy      (s_busy),
        .done      (s_done),
        .pass      (s_pass),
        .state_dbg (s_state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; close = 1'b0; np = '0; vip = '0; vvip = '0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        s_start = 1'b0; s_close = 1'b0; s_np = '0; s_vip = '0; s_vvip = '0;
        #3;
        check("rst_result", 32'(result), 0);
        check("rst_busy",   32'(busy),   0);
        check("rst_done",   32'(done),   0);
        check("rst_pass",   32'(pass),   0);
        check("rst_state",  32'(state_dbg), 32'(ST_IDLE));
        @(negedge clk);
        reset = 1'b1;

        // Main session: 8 + 32 + 16 = 56, then +8 = 64, close -> pass
        start = 1'b1;
        step();
        check("t1_busy", 32'(busy), 1);
        check("t1_result0", 32'(result), 0);
        start = 1'b0; np = 32'hf000_f000; vip = 8'hff; vvip = 1'b1;
        step();
        check("t1_result56", 32'(result), 56);
        np = 32'h0f00_0f00; vip = 8'h00; vvip = 1'b0;
        step();
        check("t1_result64", 32'(result), 64);
        np = '0; close = 1'b1;
        step();
        check("t1_done", 32'(done), 1);
        check("t1_busy_fall", 32'(busy), 0);
        check("t1_final", 32'(result), 64);
        check("t1_pass", 32'(pass), 1);
        close = 1'b0;
        step();
        check("t1_done_pulse", 32'(done), 0);
        check("t1_state_idle", 32'(state_dbg), 32'(ST_IDLE));
        check("t1_pass_hold", 32'(pass), 1);
        np = 32'hffff_ffff; vip = 8'hff; vvip = 1'b1;
        step();
        check("idle_ballots_ignored", 32'(result), 64);
        idle_inputs();

        // Repeat votes: np held 3 cycles counts once, then vip with close -> 12
        start = 1'b1;
        step();
        check("t2_cleared", 32'(result), 0);
        check("t2_pass_cleared", 32'(pass), 0);
        start = 1'b0; np = 32'h0000_00ff;
        step();
        check("t2_rep1", 32'(result), 8);
        step();
        check("t2_rep2", 32'(result), 8);
        step();
        check("t2_rep3", 32'(result), 8);
        np = '0; vip = 8'h01; close = 1'b1;
        step();
        check("t2_done", 32'(done), 1);
        check("t2_result", 32'(result), 12);
        check("t2_pass", 32'(pass), 0);
        idle_inputs();
        step();

        // start+close together in IDLE: start wins
        start = 1'b1; close = 1'b1;
        step();
        check("t3_busy", 32'(busy), 1);
        check("t3_state", 32'(state_dbg), 32'(ST_OPEN));
        check("t3_no_done", 32'(done), 0);
        start = 1'b0; close = 1'b0; np = 32'h0000_0003;
        step();
        check("t3_result2", 32'(result), 2);
        start = 1'b1;
        step();
        check("t3_start_in_open", 32'(result), 2);
        check("t3_still_busy", 32'(busy), 1);
        start = 1'b0;
        step();
        check("t3_mask_kept", 32'(result), 2);
        np = '0; close = 1'b1;
        step();
        check("t3_done", 32'(done), 1);
        check("t3_pass", 32'(pass), 0);
        idle_inputs();
        step();

        // Asynchronous reset mid-session with result=56
        start = 1'b1;
        step();
        start = 1'b0; np = 32'hf000_f000; vip = 8'hff; vvip = 1'b1;
        step();
        check("t4_pre_reset", 32'(result), 56);
        #2;
        reset = 1'b0;
        #1;
        check("t4_async_result", 32'(result), 0);
        check("t4_async_busy", 32'(busy), 0);
        check("t4_async_pass", 32'(pass), 0);
        check("t4_async_state", 32'(state_dbg), 32'(ST_IDLE));
        @(negedge clk);
        reset = 1'b1;
        step();
        step();
        check("t4_stay_idle", 32'(busy), 0);
        check("t4_result_zero", 32'(result), 0);
        idle_inputs();

        // Saturation on RES_W=6 instance: 80 clips to 63, no wrap afterwards
        s_start = 1'b1;
        step();
        s_start = 1'b0; s_np = '1; s_vip = '1; s_vvip = 1'b1;
        step();
        check("sat_clip", 32'(s_result), 63);
        step();
        check("sat_hold", 32'(s_result), 63);
        s_np = '0; s_vip = '0; s_vvip = '0; s_close = 1'b1;
        step();
        check("sat_done", 32'(s_done), 1);
        check("sat_pass", 32'(s_pass), 1);
        s_close = 1'b0;
        step();
        s_start = 1'b1;
        step();
        check("sat_restart_clear", 32'(s_result), 0);
        s_start = 1'b0; s_np = '1; s_vip = '1;
        step();
        check("sat_64_clip", 32'(s_result), 63);
        s_np = '0; s_vip = '0; s_vvip = 1'b1;
        step();
        check("sat_no_wrap", 32'(s_result), 63);
        s_vvip = '0; s_close = 1'b1;
        step();
        check("sat_final", 32'(s_result), 63);
        s_close = 1'b0;
        step();

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
